tx_trans_layer: RTL and testbench

Transmit-side transaction layer. It accepts memory requests from the software interface and completions from the internal responder, and queues each stream in its own FIFO. A round-robin arbiter selects between the two FIFOs, and a packetizer builds a 1024-bit TLP (128-bit header plus 896-bit payload). The TLP is handed to the data link layer over a valid/ready handshake.

---
 rtl/tx_tl_pkg.sv | 71 +++++++
 rtl/tx_tl_fifo.sv | 60 ++++++
 rtl/tx_trans_layer.sv | 132 +++++++++++++
 tb/tb_tx_trans_layer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_tl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_tl_pkg
// Purpose  : Shared types and constants for the transmit transaction layer:
//            TLP fmt/type codes, header bit offsets, the packed FIFO entry
//            and the TLP builder used by the packetizer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tx_tl_pkg;

  localparam int MAX_PAYLOAD_DW_DEF = 28;
  localparam int DW_W               = 32;
  localparam int HDR_W              = 128;
  localparam int PAYLOAD_W          = 896;
  localparam int PAYLOAD_DW         = PAYLOAD_W / DW_W;
  localparam int TLP_W              = HDR_W + PAYLOAD_W;

  localparam logic [2:0] FMT_MRD   = 3'b000;
  localparam logic [2:0] FMT_MWR   = 3'b010;
  localparam logic [2:0] FMT_CPLD  = 3'b010;
  localparam logic [4:0] TYPE_MRD  = 5'b00000;
  localparam logic [4:0] TYPE_MWR  = 5'b00000;
  localparam logic [4:0] TYPE_CPLD = 5'b01010;

  // fmt bit that marks a TLP as carrying a payload
  localparam int FMT_DATA_BIT = 1;

  localparam int HDR_LEN_LSB    = 0;
  localparam int HDR_TC_LSB     = 20;
  localparam int HDR_TYPE_LSB   = 24;
  localparam int HDR_FMT_LSB    = 29;
  localparam int HDR_CMPLID_LSB = 32;
  localparam int HDR_REQID_LSB  = 48;
  localparam int HDR_ADDR_LSB   = 64;

  typedef struct packed {
    logic [2:0]           fmt;
    logic [4:0]           typ;
    logic [2:0]           tc;
    logic [8:0]           length;
    logic [15:0]          request_id;
    logic [15:0]          complet_id;
    logic [31:0]          addr;
    logic [PAYLOAD_W-1:0] data;
  } tl_entry_t;

  localparam int ENTRY_W = $bits(tl_entry_t);

  // Reserved header bits stay zero; payload DWs beyond the length, or any
  // payload on a no-data fmt, are zeroed so stale bus contents never leak.
  function automatic logic [TLP_W-1:0] build_tlp(input tl_entry_t e);
    logic [TLP_W-1:0] t;
    t = '0;
    t[HDR_FMT_LSB    +: 3]  = e.fmt;
    t[HDR_TYPE_LSB   +: 5]  = e.typ;
    t[HDR_TC_LSB     +: 3]  = e.tc;
    t[HDR_LEN_LSB    +: 9]  = e.length;
    t[HDR_REQID_LSB  +: 16] = e.request_id;
    t[HDR_CMPLID_LSB +: 16] = e.complet_id;
    t[HDR_ADDR_LSB   +: 32] = e.addr;
    for (int i = 0; i < PAYLOAD_DW; i++) begin
      if (e.fmt[FMT_DATA_BIT] && (9'(i) < e.length)) begin
        t[HDR_W + DW_W*i +: DW_W] = e.data[DW_W*i +: DW_W];
      end
    end
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_tl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_tl_fifo
// Purpose  : Synchronous FIFO with wrap-bit pointers for full/empty detection.
//            Head entry is presented combinationally on o_pop_data.
// Ports    : clk, reset_n       - clock, asynchronous active-low reset
//            i_push, i_push_data - write request and entry (ignored if full)
//            i_pop               - read request (ignored if empty)
//            o_pop_data          - head entry
//            o_full, o_empty     - status flags
// Revision : 1.0 - initial release
// ============================================================================
module tx_tl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/tx_trans_layer.sv
`default_nettype none
// ============================================================================
// Module   : tx_trans_layer
// Purpose  : Transmit transaction layer. Queues software requests and
//            completions in separate FIFOs, round-robin arbitrates between
//            them and registers a 1024-bit TLP towards the data link layer.
// Ports    : clk, reset_n            - clock, asynchronous active-low reset
//            req_*                   - software request stream (valid/ready)
//            cpl_*                   - completion stream (valid/ready)
//            tlp_data_out(_valid)    - registered TLP and its valid
//            tlp_data_in_ready       - data link layer ready
//            err_len_o               - pulse when an over-length entry drops
// Revision : 1.0 - initial release
// ============================================================================
module tx_trans_layer
  import tx_tl_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_PAYLOAD_DW = MAX_PAYLOAD_DW_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt,
  input  logic [4:0]        req_type,
  input  logic [2:0]        req_tc,
  input  logic [8:0]        req_length,
  input  logic [15:0]       req_requestID,
  input  logic [15:0]       req_completID,
  input  logic [31:0]       req_addr,
  input  logic [895:0]      req_data,
  input  logic              cpl_valid,
  output logic              cpl_ready,
  input  logic [2:0]        cpl_tc,
  input  logic [8:0]        cpl_length,
  input  logic [15:0]       cpl_requestID,
  input  logic [15:0]       cpl_completID,
  input  logic [31:0]       cpl_addr,
  input  logic [895:0]      cpl_data,
  output logic [TLP_W-1:0]  tlp_data_out,
  output logic              tlp_data_out_valid,
  input  logic              tlp_data_in_ready,
  output logic              err_len_o
);

  localparam logic [8:0] LEN_LIMIT = 9'(MAX_PAYLOAD_DW);

  tl_entry_t        w_req_entry, w_cpl_entry;
  tl_entry_t        w_req_head, w_cpl_head, w_sel_entry;
  logic             w_req_full, w_req_empty, w_cpl_full, w_cpl_empty;
  logic             w_req_acc, w_cpl_acc, w_req_bad, w_cpl_bad;
  logic             w_load_en, w_grant_req, w_grant_cpl;
  logic [TLP_W-1:0] r_tlp_data;
  logic             r_tlp_valid;
  logic             r_err_len;
  logic             r_arb_ptr;   // 0: req preferred, 1: cpl preferred

  assign w_req_entry = '{fmt: req_fmt, typ: req_type, tc: req_tc,
                         length: req_length, request_id: req_requestID,
                         complet_id: req_completID, addr: req_addr,
                         data: req_data};
  assign w_cpl_entry = '{fmt: FMT_CPLD, typ: TYPE_CPLD, tc: cpl_tc,
                         length: cpl_length, request_id: cpl_requestID,
                         complet_id: cpl_completID, addr: cpl_addr,
                         data: cpl_data};

  assign req_ready = ~w_req_full;
  assign cpl_ready = ~w_cpl_full;
  assign w_req_acc = req_valid & req_ready;
  assign w_cpl_acc = cpl_valid & cpl_ready;

  // Over-length data TLPs are consumed from the source but never stored.
  assign w_req_bad = req_fmt[FMT_DATA_BIT] & (req_length > LEN_LIMIT);
  assign w_cpl_bad = (cpl_length > LEN_LIMIT);

  // Output register frees up when empty or when its TLP is taken this cycle.
  assign w_load_en   = ~r_tlp_valid | tlp_data_in_ready;
  assign w_grant_req = ~w_req_empty & (w_cpl_empty | ~r_arb_ptr);
  assign w_grant_cpl = ~w_cpl_empty & (w_req_empty |  r_arb_ptr);
  assign w_sel_entry = w_grant_req ? w_req_head : w_cpl_head;

  tx_tl_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_req_acc & ~w_req_bad),
    .i_push_data (w_req_entry),
    .i_pop       (w_load_en & w_grant_req),
    .o_pop_data  (w_req_head),
    .o_full      (w_req_full),
    .o_empty     (w_req_empty)
  );

  tx_tl_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_cpl_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_cpl_acc & ~w_cpl_bad),
    .i_push_data (w_cpl_entry),
    .i_pop       (w_load_en & w_grant_cpl),
    .o_pop_data  (w_cpl_head),
    .o_full      (w_cpl_full),
    .o_empty     (w_cpl_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tlp_data  <= '0;
      r_tlp_valid <= 1'b0;
      r_err_len   <= 1'b0;
      r_arb_ptr   <= 1'b0;
    end else begin
      // Simultaneous drops on both sources collapse into one pulse.
      r_err_len <= (w_req_acc & w_req_bad) | (w_cpl_acc & w_cpl_bad);
      if (w_load_en) begin
        if (w_grant_req | w_grant_cpl) begin
          r_tlp_data  <= build_tlp(w_sel_entry);
          r_tlp_valid <= 1'b1;
          // Point at the source that lost this round.
          r_arb_ptr   <= w_grant_req;
        end else begin
          r_tlp_valid <= 1'b0;
        end
      end
    end
  end

  assign tlp_data_out       = r_tlp_data;
  assign tlp_data_out_valid = r_tlp_valid;
  assign err_len_o          = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_tx_trans_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_trans_layer
// Purpose  : Self-checking bench for tx_trans_layer: vector table for single
//            TLPs plus directed sequences for arbitration, backpressure,
//            length errors and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_trans_layer;

  localparam int DEPTH = 4;
  localparam int MAXDW = 28;

  typedef struct packed {
    logic         v;
    logic [2:0]   fmt;
    logic [4:0]   typ;
    logic [2:0]   tc;
    logic [8:0]   len;
    logic [15:0]  rid;
    logic [15:0]  cid;
    logic [31:0]  addr;
    logic [895:0] data;
  } txn_t;

  typedef struct {
    txn_t        t;
    logic [31:0] exp_hdr;
    logic [31:0] exp_addr;
    logic [31:0] exp_p0;
    logic [31:0] exp_p1;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, cpl_valid, cpl_ready;
  logic [2:0]    req_fmt, req_tc, cpl_tc;
  logic [4:0]    req_type;
  logic [8:0]    req_length, cpl_length;
  logic [15:0]   req_requestID, req_completID, cpl_requestID, cpl_completID;
  logic [31:0]   req_addr, cpl_addr;
  logic [895:0]  req_data, cpl_data;
  logic [1023:0] tlp_data_out;
  logic          tlp_data_out_valid, tlp_data_in_ready, err_len_o;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [1023:0] sb_q[$];

  always #5 clk = ~clk;

  tx_trans_layer #(.FIFO_DEPTH(DEPTH), .MAX_PAYLOAD_DW(MAXDW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .req_type(req_type), .req_tc(req_tc), .req_length(req_length),
    .req_requestID(req_requestID), .req_completID(req_completID),
    .req_addr(req_addr), .req_data(req_data),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tc(cpl_tc),
    .cpl_length(cpl_length), .cpl_requestID(cpl_requestID),
    .cpl_completID(cpl_completID), .cpl_addr(cpl_addr), .cpl_data(cpl_data),
    .tlp_data_out(tlp_data_out), .tlp_data_out_valid(tlp_data_out_valid),
    .tlp_data_in_ready(tlp_data_in_ready), .err_len_o(err_len_o)
  );

  // Reference TLP: header assembled as one concatenation, payload masked.
  function automatic logic [1023:0] model_tlp(input txn_t t);
    logic [1023:0] r;
    r = '0;
    r[127:0] = {32'h0, t.addr, t.rid, t.cid, t.fmt, t.typ, 1'b0, t.tc,
                11'h0, t.len};
    if (t.fmt[1])
      for (int i = 0; i < 28; i++)
        if (i < int'(t.len)) r[128 + 32*i +: 32] = t.data[32*i +: 32];
    return r;
  endfunction

  function automatic logic [895:0] mk_data(input int mode);
    logic [895:0] d;
    for (int i = 0; i < 28; i++) begin
      case (mode)
        0:       d[32*i +: 32] = (i == 0) ? 32'hA5A5A5A5 :
                                 (i == 1) ? 32'h5A5A5A5A : 32'h000000FF;
        1:       d[32*i +: 32] = 32'hFFFFFFFF;
        default: d[32*i +: 32] = 32'hD0000000 + 32'(i);
      endcase
    end
    return d;
  endfunction

  function automatic txn_t mk_req(input logic [2:0] fmt, input logic [4:0] typ,
                                  input logic [2:0] tc, input logic [8:0] len,
                                  input logic [31:0] addr, input int mode);
    txn_t t;
    t.v = 1'b1; t.fmt = fmt; t.typ = typ; t.tc = tc; t.len = len;
    t.rid = 16'hA001; t.cid = 16'h0000 ^ addr[15:0]; t.addr = addr;
    t.data = mk_data(mode);
    return t;
  endfunction

  function automatic txn_t mk_cpl(input logic [8:0] len, input logic [31:0] addr,
                                  input int mode);
    txn_t t;
    t.v = 1'b1; t.fmt = 3'b010; t.typ = 5'b01010; t.tc = 3'd2; t.len = len;
    t.rid = 16'hA001; t.cid = 16'hB002; t.addr = addr; t.data = mk_data(mode);
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_tlp(input string name, input logic [1023:0] act,
                           input logic [1023:0] exp);
    int k;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      k = 0;
      for (int i = 31; i >= 0; i--)
        if (act[32*i +: 32] !== exp[32*i +: 32]) k = i;
      $display("FAIL %s: dw%0d actual=%h required=%h", name, k,
               act[32*k +: 32], exp[32*k +: 32]);
    end
  endtask

  // Scoreboard: every TLP accepted by the link layer must match the head.
  always @(negedge clk) begin
    if (reset_n && tlp_data_out_valid && tlp_data_in_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tlp: actual hdr=%h required no TLP",
                 tlp_data_out[31:0]);
      end else begin
        check_tlp("scoreboard", tlp_data_out, sb_q.pop_front());
      end
    end
  end

  // Drives one cycle of stimulus; called at posedge+1, returns at posedge+1.
  task automatic drive(input txn_t r, input txn_t c,
                       output logic r_acc, output logic c_acc);
    req_valid = r.v; req_fmt = r.fmt; req_type = r.typ; req_tc = r.tc;
    req_length = r.len; req_requestID = r.rid; req_completID = r.cid;
    req_addr = r.addr; req_data = r.data;
    cpl_valid = c.v; cpl_tc = c.tc; cpl_length = c.len;
    cpl_requestID = c.rid; cpl_completID = c.cid; cpl_addr = c.addr;
    cpl_data = c.data;
    r_acc = r.v & req_ready;
    c_acc = c.v & cpl_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cpl_valid = 1'b0;
    if (r_acc && !(r.fmt[1] && r.len > 9'(MAXDW))) sb_q.push_back(model_tlp(r));
    if (c_acc && !(c.len > 9'(MAXDW)))             sb_q.push_back(model_tlp(c));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((sb_q.size() != 0 || tlp_data_out_valid) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_queue"}, 64'(sb_q.size()), 64'd0);
    check({name, "_idle"}, 64'(tlp_data_out_valid), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    txn_t idle;
    logic ra, ca;
    logic [1023:0] first;
    int run, acc_cnt, seen;
    logic stable;

    idle = '0;
    vecs[0] = '{mk_req(3'b010, 5'd0, 3'd1, 9'd2, 32'h1000, 0),
                32'h40100002, 32'h1000, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[1] = '{mk_req(3'b000, 5'd0, 3'd0, 9'd4, 32'h2000, 1),
                32'h00000004, 32'h2000, 32'h0, 32'h0};
    vecs[2] = '{mk_req(3'b010, 5'd0, 3'd7, 9'd28, 32'h3000, 2),
                32'h4070001C, 32'h3000, 32'hD0000000, 32'hD0000001};
    vecs[3] = '{mk_req(3'b011, 5'd0, 3'd0, 9'd0, 32'h4000, 1),
                32'h60000000, 32'h4000, 32'h0, 32'h0};
    vecs[4] = '{mk_req(3'b010, 5'd1, 3'd3, 9'd1, 32'h5000, 2),
                32'h41300001, 32'h5000, 32'hD0000000, 32'h0};

    reset_n = 1'b0; tlp_data_in_ready = 1'b1;
    req_valid = 1'b0; req_fmt = '0; req_type = '0; req_tc = '0;
    req_length = '0; req_requestID = '0; req_completID = '0;
    req_addr = '0; req_data = '0;
    cpl_valid = 1'b0; cpl_tc = '0; cpl_length = '0; cpl_requestID = '0;
    cpl_completID = '0; cpl_addr = '0; cpl_data = '0;
    #1;
    check("rst_valid", 64'(tlp_data_out_valid), 64'd0);
    check("rst_data", 64'(|tlp_data_out), 64'd0);
    check("rst_err", 64'(err_len_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_cpl_ready", 64'(cpl_ready), 64'd1);

    // Single-TLP vectors: exact two-edge latency and one-cycle valid.
    for (int v = 0; v < 5; v++) begin
      drive(vecs[v].t, idle, ra, ca);
      check("vec_accept", 64'(ra), 64'd1);
      check("vec_not_early", 64'(tlp_data_out_valid), 64'd0);
      @(posedge clk); #1;
      check("vec_valid", 64'(tlp_data_out_valid), 64'd1);
      check("vec_hdr", 64'(tlp_data_out[31:0]), 64'(vecs[v].exp_hdr));
      check("vec_addr", 64'(tlp_data_out[95:64]), 64'(vecs[v].exp_addr));
      check("vec_p0", 64'(tlp_data_out[159:128]), 64'(vecs[v].exp_p0));
      check("vec_p1", 64'(tlp_data_out[191:160]), 64'(vecs[v].exp_p1));
      @(posedge clk); #1;
      check("vec_one_cycle", 64'(tlp_data_out_valid), 64'd0);
    end
    wait_drain("vec_drain", 20);

    // Both sources, three entries each: strict alternation starting at req.
    do_reset();
    for (int k = 0; k < 3; k++)
      drive(mk_req(3'b010, 5'd0, 3'd0, 9'(k + 1), 32'h100 * (k + 1), 2),
            mk_cpl(9'(k + 2), 32'h10 + 32'(k), 1), ra, ca);
    check("cpl_hdr_byte", 64'(tlp_data_out[31:24]), 64'h4A);
    run = 0;
    for (int k = 0; k < 10; k++) begin
      if (tlp_data_out_valid && run == k) run++;
      @(posedge clk); #1;
    end
    check("b2b_run", 64'(run), 64'd5);
    wait_drain("rr_drain", 20);

    // Backpressure: five accepted (1 in output reg + 4 in FIFO), sixth refused.
    tlp_data_in_ready = 1'b0;
    acc_cnt = 0;
    first = '0;
    for (int k = 0; k < 6; k++) begin
      drive(mk_req(3'b010, 5'd0, 3'd1, 9'(k + 3), 32'h8000 + 32'(k), 2),
            idle, ra, ca);
      acc_cnt += int'(ra);
      if (k == 1) first = tlp_data_out;
    end
    check("bp_accepted", 64'(acc_cnt), 64'd5);
    check("bp_req_ready", 64'(req_ready), 64'd0);
    stable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (!(tlp_data_out_valid && tlp_data_out === first)) stable = 1'b0;
      @(posedge clk); #1;
    end
    check("bp_hold_stable", 64'(stable), 64'd1);
    tlp_data_in_ready = 1'b1;
    wait_drain("bp_drain", 30);

    // Length boundary: 29 dropped with one error pulse, 28 passes.
    drive(mk_req(3'b010, 5'd0, 3'd0, 9'd29, 32'h9000, 2), idle, ra, ca);
    check("len29_ready", 64'(ra), 64'd1);
    check("len29_err", 64'(err_len_o), 64'd1);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) check("len29_err_clear", 64'(err_len_o), 64'd0);
      seen += int'(tlp_data_out_valid);
    end
    check("len29_no_tlp", 64'(seen), 64'd0);
    drive(mk_req(3'b010, 5'd0, 3'd0, 9'd28, 32'h9100, 2), idle, ra, ca);
    check("len28_err", 64'(err_len_o), 64'd0);
    wait_drain("len28_drain", 20);
    drive(mk_req(3'b000, 5'd0, 3'd0, 9'd100, 32'h9200, 1), idle, ra, ca);
    check("mrd_long_err", 64'(err_len_o), 64'd0);
    wait_drain("mrd_long_drain", 20);
    drive(mk_req(3'b010, 5'd0, 3'd0, 9'd29, 32'h9300, 2),
          mk_cpl(9'd30, 32'h9400, 2), ra, ca);
    check("both_bad_err", 64'(err_len_o), 64'd1);
    @(posedge clk); #1;
    check("both_bad_single", 64'(err_len_o), 64'd0);
    wait_drain("both_bad_drain", 10);

    // Asynchronous reset with a TLP held and both FIFOs occupied.
    tlp_data_in_ready = 1'b0;
    drive(mk_req(3'b010, 5'd0, 3'd0, 9'd2, 32'hA000, 2),
          mk_cpl(9'd2, 32'hA100, 2), ra, ca);
    drive(mk_req(3'b010, 5'd0, 3'd0, 9'd2, 32'hA200, 2),
          mk_cpl(9'd2, 32'hA300, 2), ra, ca);
    check("mid_pre_valid", 64'(tlp_data_out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(tlp_data_out_valid), 64'd0);
    check("mid_rst_data", 64'(|tlp_data_out), 64'd0);
    sb_q.delete();
    tlp_data_in_ready = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      seen += int'(tlp_data_out_valid);
      @(posedge clk); #1;
    end
    check("mid_nothing_after", 64'(seen), 64'd0);
    drive(mk_req(3'b010, 5'd0, 3'd5, 9'd3, 32'hB000, 0), idle, ra, ca);
    wait_drain("post_rst_drain", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
